gshare_predictor: RTL and testbench
===================================

GSHARE_PREDICTOR -- requirements
Module: GSHARE_PREDICTOR

Interface
REQ-001 SHALL provide parameter SCALE, default 10: table index width; the table holds 2^SCALE 2-bit counters.
REQ-002 SHALL provide parameter HIST, default 8: global history width, legal range 1..SCALE.
REQ-003 SHALL provide parameter MODE, default 1: 0 = bimodal indexing, 1 = gshare indexing.
REQ-004 SHALL provide parameter INIT_CNT, default 2'b01: counter value written at initialisation (weakly not-taken).
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port bp_pc, input, 32 bits: fetch PC to predict.
REQ-008 SHALL have port bp_oe, input, 1 bit: prediction read enable.
REQ-009 SHALL have port bp_taken, output, 1 bit: registered prediction.
REQ-010 SHALL have port bp_data, output, SCALE+2 bits: {index, counter} for the prediction; the pipeline carries it to feedback.
REQ-011 SHALL have port fb_taken, input, 1 bit: resolved branch direction.
REQ-012 SHALL have port fb_we, input, 1 bit: feedback strobe for a resolved control-transfer instruction.
REQ-013 SHALL have port fb_data, input, SCALE+2 bits: the bp_data value returned with that instruction.
REQ-014 SHALL have port ready, output, 1 bit: table initialisation is complete.
REQ-015 SHALL have port stat_fb, output, 32 bits: count of accepted feedbacks.
REQ-016 SHALL have port stat_miss, output, 32 bits: count of mispredicted feedbacks.

Function
REQ-017 SHALL implement a two-state FSM, INIT and RUN; rst forces INIT, and INIT moves to RUN after 2^SCALE cycles.
REQ-018 In INIT, SHALL write INIT_CNT to entry init_idx each cycle, with init_idx starting at 0 and incrementing by 1; the cycle that writes the last entry moves the FSM to RUN.
REQ-019 SHALL drive ready to 1 exactly when the FSM is in RUN.
REQ-020 In INIT, SHALL ignore fb_we, hold bp_taken at 0 and bp_data at 0, and hold the GHR at 0.
REQ-021 SHALL compute the prediction index as bp_pc[2+:SCALE] when MODE=0, and as bp_pc[2+:SCALE] XOR zero-extended GHR[HIST-1:0] when MODE=1.
REQ-022 When bp_oe=1 and in RUN, SHALL at the next edge register bp_data = {index, table[index]} and bp_taken = table[index][1]; prediction latency is 1 cycle.
REQ-023 When bp_oe=0, SHALL hold bp_taken and bp_data at their previous values.
REQ-024 When fb_we=1 and in RUN, SHALL write the new counter to entry fb_data[SCALE+1:2]; the write uses the carried index, never a recomputed one.
REQ-025 SHALL compute the new counter from fb_data[1:0] as a saturating update: if taken, 11 stays 11, otherwise add 1; if not taken, 00 stays 00, otherwise subtract 1.
REQ-026 When a feedback write and a prediction read hit the same index in the same cycle, SHALL return the newly written counter (write-first bypass).
REQ-027 When MODE=1 and fb_we=1 in RUN, SHALL update the GHR non-speculatively as GHR <= {GHR[HIST-2:0], fb_taken}; when HIST=1, GHR <= fb_taken.
REQ-028 A prediction in the same cycle as a GHR update SHALL use the pre-update GHR.
REQ-029 When MODE=0, SHALL hold the GHR at 0.
REQ-030 On each accepted feedback, SHALL increment stat_fb by 1, saturating at 32'hFFFFFFFF.
REQ-031 On each accepted feedback with fb_taken != fb_data[1], SHALL increment stat_miss by 1, saturating at 32'hFFFFFFFF.
REQ-032 SHALL not decode bp_pc[1:0] or bp_pc above bit SCALE+1.

Reset
REQ-033 When rst=1 at an edge, SHALL set: FSM INIT, init_idx 0, ready 0, bp_taken 0, bp_data 0, GHR 0, stat_fb 0, stat_miss 0.
REQ-034 When rst is asserted mid-operation, SHALL drop ready on the next cycle, discard any concurrent feedback, and fully re-initialise the table.
REQ-035 SHALL make the first RUN cycle the (2^SCALE)+1-th cycle after rst deasserts.

Verification
REQ-036 SCALE=4: deassert rst, hold bp_oe=1 -> ready=0 and bp_taken=0 for 16 cycles, then ready=1; every entry reads 01.
REQ-037 MODE=0, SCALE=4: predict 0x44 -> bp_data={4'h1,2'b01}, bp_taken=0; feed back taken twice, chaining the returned data -> counter 11, next predict of 0x44 gives bp_taken=1.
REQ-038 Saturation: fb_data={idx,11} with fb_taken=1 -> entry stays 11, stat_miss unchanged; fb_data={idx,00} with fb_taken=0 -> entry stays 00.
REQ-039 MODE=1, HIST=4, SCALE=4: feed back T,T,N,T -> GHR=4'b1101; predict pc 0x0 -> index 4'hD.
REQ-040 Same-cycle fb_we to index 3 (01->10) and bp_oe at index 3 -> bp_data={4'h3,2'b10} and bp_taken=1.
REQ-041 After 5 feedbacks including 2 mispredictions, pulse rst -> stats go 5/2 -> 0/0, ready=0, and the 16-cycle initialisation repeats.

Source files
------------

// File: rtl/gshare_predictor.sv
// Branch direction predictor built from a table of 2-bit saturating counters, indexed
// bimodally or gshare-style, with a self-initialising table and feedback statistics.
module gshare_predictor #(
  parameter int         SCALE    = 10,
  parameter int         HIST     = 8,
  parameter int         MODE     = 1,
  parameter logic [1:0] INIT_CNT = 2'b01
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      bp_pc,
  input  logic             bp_oe,
  output logic             bp_taken,
  output logic [SCALE+1:0] bp_data,
  input  logic             fb_taken,
  input  logic             fb_we,
  input  logic [SCALE+1:0] fb_data,
  output logic             ready,
  output logic [31:0]      stat_fb,
  output logic [31:0]      stat_miss
);

  typedef enum logic {INIT, RUN} state_t;

  localparam int DEPTH = 1 << SCALE;

  state_t           r_state;
  logic [SCALE-1:0] r_initIdx;
  logic [1:0]       r_table [DEPTH];
  logic [HIST-1:0]  r_ghr;
  logic             r_ready;
  logic             r_taken;
  logic [SCALE+1:0] r_data;
  logic [31:0]      r_statFb;
  logic [31:0]      r_statMiss;

  logic             w_run;
  logic             w_fbAccept;
  logic [SCALE-1:0] w_fbIdx;
  logic [1:0]       w_fbCnt;
  logic [1:0]       w_newCnt;
  logic [SCALE-1:0] w_ghrExt;
  logic [SCALE-1:0] w_predIdx;
  logic [1:0]       w_predCnt;
  logic             w_unusedPc;

  assign w_run      = (r_state == RUN);
  assign w_fbAccept = fb_we && w_run;
  assign w_fbIdx    = fb_data[SCALE+1:2];
  assign w_fbCnt    = fb_data[1:0];
  assign w_ghrExt   = (MODE == 1) ? SCALE'(r_ghr) : '0;
  assign w_predIdx  = bp_pc[2+:SCALE] ^ w_ghrExt;
  assign w_unusedPc = ^{bp_pc[1:0], bp_pc[31:SCALE+2]};

  always_comb begin
    w_newCnt = w_fbCnt;
    if (fb_taken) begin
      if (w_fbCnt != 2'b11) w_newCnt = w_fbCnt + 2'b01;
    end else begin
      if (w_fbCnt != 2'b00) w_newCnt = w_fbCnt - 2'b01;
    end
  end

  // A read colliding with this cycle's feedback write sees the new counter.
  assign w_predCnt = (w_fbAccept && (w_fbIdx == w_predIdx)) ? w_newCnt : r_table[w_predIdx];

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (r_state == INIT) begin
        r_table[r_initIdx] <= INIT_CNT;
      end else if (fb_we) begin
        r_table[w_fbIdx] <= w_newCnt;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= INIT;
      r_initIdx  <= '0;
      r_ready    <= 1'b0;
      r_taken    <= 1'b0;
      r_data     <= '0;
      r_ghr      <= '0;
      r_statFb   <= '0;
      r_statMiss <= '0;
    end else begin
      case (r_state)
        INIT: begin
          r_initIdx <= r_initIdx + 1'b1;
          if (r_initIdx == '1) begin
            r_state <= RUN;
            r_ready <= 1'b1;
          end
        end
        RUN: begin
          if (bp_oe) begin
            r_taken <= w_predCnt[1];
            r_data  <= {w_predIdx, w_predCnt};
          end
          if (fb_we) begin
            if (r_statFb != 32'hFFFF_FFFF) r_statFb <= r_statFb + 32'd1;
            if ((fb_taken != fb_data[1]) && (r_statMiss != 32'hFFFF_FFFF))
              r_statMiss <= r_statMiss + 32'd1;
            // History shifts only on resolved branches, so it never needs repair.
            if (MODE == 1) r_ghr <= HIST'({r_ghr, fb_taken});
          end
        end
        default: r_state <= INIT;
      endcase
    end
  end

  assign ready     = r_ready;
  assign bp_taken  = r_taken;
  assign bp_data   = r_data;
  assign stat_fb   = r_statFb;
  assign stat_miss = r_statMiss;

endmodule

// File: tb/tb_gshare_predictor.sv
// Bench for gshare_predictor: a bimodal and a gshare instance share stimulus and are
// compared against an array-based model plus directed spec examples.
module tb_gshare_predictor;

  localparam int SCALE = 4;
  localparam int HIST  = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] bpPc;
  logic        bpOe;
  logic        fbTaken;
  logic        fbWe;
  logic [5:0]  fbData;

  logic [1:0]        oTaken;
  logic [1:0][5:0]   oData;
  logic [1:0]        oReady;
  logic [1:0][31:0]  oFb;
  logic [1:0][31:0]  oMiss;

  logic [1:0]        eTaken;
  logic [1:0][5:0]   eData;
  logic [1:0]        eReady;
  logic [1:0][31:0]  eFb;
  logic [1:0][31:0]  eMiss;

  int mTable [2][16];
  int mLeft  [2];
  int mGhr   [2];

  int checks = 0;
  int errors = 0;

  gshare_predictor #(.SCALE(SCALE), .HIST(HIST), .MODE(0), .INIT_CNT(2'b01)) dut0 (
    .clk(clk), .rst(rst), .bp_pc(bpPc), .bp_oe(bpOe), .bp_taken(oTaken[0]),
    .bp_data(oData[0]), .fb_taken(fbTaken), .fb_we(fbWe), .fb_data(fbData),
    .ready(oReady[0]), .stat_fb(oFb[0]), .stat_miss(oMiss[0])
  );

  gshare_predictor #(.SCALE(SCALE), .HIST(HIST), .MODE(1), .INIT_CNT(2'b01)) dut1 (
    .clk(clk), .rst(rst), .bp_pc(bpPc), .bp_oe(bpOe), .bp_taken(oTaken[1]),
    .bp_data(oData[1]), .fb_taken(fbTaken), .fb_we(fbWe), .fb_data(fbData),
    .ready(oReady[1]), .stat_fb(oFb[1]), .stat_miss(oMiss[1])
  );

  always #5 clk = ~clk;

  // Reference: one pass per clock edge over each table, history and counter set.
  task automatic modelStep();
    for (int m = 0; m < 2; m++) begin
      if (rst) begin
        mLeft[m] = 16;
        mGhr[m]  = 0;
        eData[m] = '0;
        eTaken[m] = 1'b0;
        eFb[m]   = '0;
        eMiss[m] = '0;
      end else if (mLeft[m] > 0) begin
        mTable[m][16 - mLeft[m]] = 1;
        mLeft[m]--;
      end else begin
        int idx, fi, c, nc;
        idx = ((bpPc >> 2) & 15) ^ ((m == 1) ? mGhr[m] : 0);
        if (fbWe) begin
          fi = int'(fbData) >> 2;
          c  = int'(fbData) & 3;
          nc = fbTaken ? ((c == 3) ? 3 : c + 1) : ((c == 0) ? 0 : c - 1);
          mTable[m][fi] = nc;
          if (eFb[m] != 32'hFFFF_FFFF) eFb[m] = eFb[m] + 1;
          if ((fbTaken ? 1 : 0) != ((c >= 2) ? 1 : 0) && eMiss[m] != 32'hFFFF_FFFF)
            eMiss[m] = eMiss[m] + 1;
          if (m == 1) mGhr[m] = ((mGhr[m] << 1) | (fbTaken ? 1 : 0)) & 15;
        end
        if (bpOe) begin
          eData[m]  = 6'((idx << 2) | mTable[m][idx]);
          eTaken[m] = (mTable[m][idx] >= 2);
        end
      end
      eReady[m] = (mLeft[m] == 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic applyStimulus(input logic oe, input logic [31:0] pc, input logic we,
                               input logic tk, input logic [5:0] fd);
    bpOe = oe; bpPc = pc; fbWe = we; fbTaken = tk; fbData = fd;
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (16) tick();
  endtask

  task automatic test_reset();
    applyStimulus(1'b1, $urandom, 1'b0, 1'b0, 6'h0);
    rst = 1'b1;
    tick();
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (oReady[m] !== 1'b0 || oTaken[m] !== 1'b0 || oData[m] !== 6'h0 ||
          oFb[m] !== 32'h0 || oMiss[m] !== 32'h0) begin
        errors++;
        $display("[TB] FAIL reset_state m=%0d got rdy=%b tk=%b data=%h fb=%0d miss=%0d exp all 0",
                 m, oReady[m], oTaken[m], oData[m], oFb[m], oMiss[m]);
      end
    end
    rst = 1'b0;
    for (int cyc = 1; cyc <= 16; cyc++) begin
      bpPc = $urandom;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (oReady[m] !== (cyc == 16) || oTaken[m] !== 1'b0 || oData[m] !== 6'h0) begin
          errors++;
          $display("[TB] FAIL init_seq m=%0d cyc=%0d got rdy=%b tk=%b data=%h exp rdy=%b tk=0 data=00",
                   m, cyc, oReady[m], oTaken[m], oData[m], (cyc == 16));
        end
      end
    end
    for (int i = 0; i < 16; i++) begin
      logic [3:0] idx4;
      idx4 = 4'(i);
      bpPc = 32'(i) << 2;
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (oData[m] !== {idx4, 2'b01} || oTaken[m] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL init_entry m=%0d i=%0d got data=%h tk=%b exp data=%h tk=0",
                   m, i, oData[m], oTaken[m], {idx4, 2'b01});
        end
      end
    end
  endtask

  task automatic test_mode0_counter();
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 6'h0);
    tick();
    checks++;
    if (oData[0] !== 6'b000101 || oTaken[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL m0_predict44 got data=%h tk=%b exp data=05 tk=0", oData[0], oTaken[0]);
    end
    applyStimulus(1'b0, 32'h44, 1'b1, 1'b1, 6'b000101);
    tick();
    applyStimulus(1'b0, 32'h44, 1'b1, 1'b1, 6'b000110);
    tick();
    applyStimulus(1'b1, 32'h44, 1'b0, 1'b0, 6'h0);
    tick();
    checks++;
    if (oData[0] !== 6'b000111 || oTaken[0] !== 1'b1) begin
      errors++;
      $display("[TB] FAIL m0_trained got data=%h tk=%b exp data=07 tk=1", oData[0], oTaken[0]);
    end
    checks++;
    if (oData[1] !== eData[1] || oTaken[1] !== eTaken[1]) begin
      errors++;
      $display("[TB] FAIL m1_after_train got data=%h tk=%b exp data=%h tk=%b",
               oData[1], oTaken[1], eData[1], eTaken[1]);
    end
  endtask

  task automatic test_saturation();
    logic [31:0] missBefore;
    missBefore = eMiss[0];
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b1, {4'h5, 2'b11});
    tick();
    applyStimulus(1'b1, 32'h5 << 2, 1'b0, 1'b0, 6'h0);
    tick();
    checks++;
    if (oData[0] !== {4'h5, 2'b11} || oMiss[0] !== missBefore) begin
      errors++;
      $display("[TB] FAIL sat_high got data=%h miss=%0d exp data=%h miss=%0d",
               oData[0], oMiss[0], {4'h5, 2'b11}, missBefore);
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, {4'h6, 2'b00});
    tick();
    applyStimulus(1'b1, 32'h6 << 2, 1'b0, 1'b0, 6'h0);
    tick();
    checks++;
    if (oData[0] !== {4'h6, 2'b00} || oTaken[0] !== 1'b0) begin
      errors++;
      $display("[TB] FAIL sat_low got data=%h tk=%b exp data=%h tk=0",
               oData[0], oTaken[0], {4'h6, 2'b00});
    end
    checks++;
    if (oData[1] !== eData[1] || oMiss[1] !== eMiss[1]) begin
      errors++;
      $display("[TB] FAIL sat_m1 got data=%h miss=%0d exp data=%h miss=%0d",
               oData[1], oMiss[1], eData[1], eMiss[1]);
    end
  endtask

  task automatic test_ghr();
    logic pattern [4];
    pattern = '{1'b1, 1'b1, 1'b0, 1'b1};
    doReset();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, pattern[i], 6'h0);
      tick();
    end
    applyStimulus(1'b1, 32'h0, 1'b0, 1'b0, 6'h0);
    tick();
    checks++;
    if (oData[1] !== {4'hD, 2'b01}) begin
      errors++;
      $display("[TB] FAIL ghr_index got data=%h exp data=%h", oData[1], {4'hD, 2'b01});
    end
    checks++;
    if (oData[0][5:2] !== 4'h0) begin
      errors++;
      $display("[TB] FAIL bimodal_no_ghr got idx=%h exp idx=0", oData[0][5:2]);
    end
  endtask

  task automatic test_bypass();
    doReset();
    applyStimulus(1'b1, 32'hC, 1'b1, 1'b1, {4'h3, 2'b01});
    tick();
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (oData[m] !== {4'h3, 2'b10} || oTaken[m] !== 1'b1) begin
        errors++;
        $display("[TB] FAIL bypass m=%0d got data=%h tk=%b exp data=%h tk=1",
                 m, oData[m], oTaken[m], {4'h3, 2'b10});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic seq [5];
    seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    doReset();
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 32'h0, 1'b1, seq[i], {4'h7, 2'b01});
      tick();
    end
    fbWe = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (oFb[m] !== 32'd5 || oMiss[m] !== 32'd2) begin
        errors++;
        $display("[TB] FAIL stats_before m=%0d got fb=%0d miss=%0d exp fb=5 miss=2", m, oFb[m], oMiss[m]);
      end
    end
    applyStimulus(1'b1, $urandom, 1'b1, 1'b1, {4'h7, 2'b01});
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int m = 0; m < 2; m++) begin
      checks++;
      if (oFb[m] !== 32'd0 || oMiss[m] !== 32'd0 || oReady[m] !== 1'b0) begin
        errors++;
        $display("[TB] FAIL stats_cleared m=%0d got fb=%0d miss=%0d rdy=%b exp 0/0 rdy=0",
                 m, oFb[m], oMiss[m], oReady[m]);
      end
    end
    for (int cyc = 1; cyc <= 16; cyc++) begin
      tick();
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (oReady[m] !== (cyc == 16) || oFb[m] !== 32'd0 || oTaken[m] !== 1'b0) begin
          errors++;
          $display("[TB] FAIL reinit m=%0d cyc=%0d got rdy=%b fb=%0d tk=%b exp rdy=%b fb=0 tk=0",
                   m, cyc, oReady[m], oFb[m], oTaken[m], (cyc == 16));
        end
      end
    end
    fbWe = 1'b0;
  endtask

  task automatic test_random();
    for (int n = 0; n < 600; n++) begin
      logic [5:0] fd;
      fd = ($urandom_range(0, 1) == 0) ? eData[$urandom_range(0, 1)] : 6'($urandom);
      applyStimulus(1'($urandom), $urandom, 1'($urandom), 1'($urandom), fd);
      rst = ($urandom_range(0, 149) == 0);
      tick();
      rst = 1'b0;
      for (int m = 0; m < 2; m++) begin
        checks++;
        if (oReady[m] !== eReady[m] || oTaken[m] !== eTaken[m] || oData[m] !== eData[m] ||
            oFb[m] !== eFb[m] || oMiss[m] !== eMiss[m]) begin
          errors++;
          $display("[TB] FAIL random m=%0d n=%0d got rdy=%b tk=%b data=%h fb=%0d miss=%0d exp rdy=%b tk=%b data=%h fb=%0d miss=%0d",
                   m, n, oReady[m], oTaken[m], oData[m], oFb[m], oMiss[m],
                   eReady[m], eTaken[m], eData[m], eFb[m], eMiss[m]);
        end
      end
    end
  endtask

  initial begin
    for (int m = 0; m < 2; m++) begin
      mLeft[m] = 16;
      mGhr[m]  = 0;
      for (int i = 0; i < 16; i++) mTable[m][i] = 0;
    end
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 6'h0);
    test_reset();
    test_mode0_counter();
    test_saturation();
    test_ghr();
    test_bypass();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
